// File: rtl/packet_types.sv
// Shared packet-level types for the NoC packet path.
package packet_types;

    localparam int PACKET_ID_W = 8;

    // One completed packet as presented by a packet_buffer.
    typedef struct packed {
        logic [PACKET_ID_W-1:0] packet_id;
        logic [7:0]             dest;
        logic [7:0]             length;
        logic [15:0]            addr;
    } packet_element_t;

    // States of the packet transfer arbiter.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from rr_ptr, wrapping NUM_SOURCES-1 -> 0.
module rr_priority_picker #(
    parameter int NUM_SOURCES = 4,
    parameter int SRC_IDX_W   = $clog2(NUM_SOURCES)  // derived; do not override
) (
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [SRC_IDX_W-1:0]   rr_ptr,
    output logic                   found,
    output logic [SRC_IDX_W-1:0]   idx
);

    int                   cand;
    logic [SRC_IDX_W-1:0] cand_idx;

    // Walk the request vector from rr_ptr and keep the first hit.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cand     = (int'(rr_ptr) + i) % NUM_SOURCES;
            cand_idx = cand[SRC_IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/packet_transfer_arbiter.sv
// Round-robin arbiter sharing one downstream packet consumer between
// NUM_SOURCES packet buffers. All outputs come straight from flops.
module packet_transfer_arbiter
    import packet_types::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int SRC_IDX_W   = $clog2(NUM_SOURCES)  // derived; do not override
) (
    input  logic                                nocclk,
    input  logic                                rst,
    input  packet_element_t [NUM_SOURCES-1:0]   src_packet,
    input  logic [NUM_SOURCES-1:0]              src_valid,
    output logic [NUM_SOURCES-1:0]              src_completed,
    output packet_element_t                     out_packet,
    output logic [SRC_IDX_W-1:0]                out_source,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy
);

    arb_state_t             state_q, state_d;
    logic [SRC_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    packet_element_t        out_packet_q, out_packet_d;
    logic [SRC_IDX_W-1:0]   out_source_q, out_source_d;
    logic                   out_valid_q, out_valid_d;
    logic [NUM_SOURCES-1:0] src_completed_q, src_completed_d;
    logic                   busy_q, busy_d;

    logic [NUM_SOURCES-1:0] candidates;
    logic                   pick_found;
    logic [SRC_IDX_W-1:0]   pick_idx;

    function automatic logic [NUM_SOURCES-1:0] onehot(input logic [SRC_IDX_W-1:0] i);
        logic [NUM_SOURCES-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // The mask is only non-zero in the first IDLE cycle after a release, so a
    // source whose valid is still high then cannot be granted the same packet twice.
    assign candidates = src_valid & ~mask_q;

    rr_priority_picker #(
        .NUM_SOURCES (NUM_SOURCES),
        .SRC_IDX_W   (SRC_IDX_W)
    ) u_picker (
        .req    (candidates),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Next-state and next-output logic of the grant/offer/release FSM.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        mask_d          = '0;
        out_packet_d    = out_packet_q;
        out_source_d    = out_source_q;
        out_valid_d     = 1'b0;
        src_completed_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d      = OFFER;
                    out_packet_d = src_packet[pick_idx];
                    out_source_d = pick_idx;
                    out_valid_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OFFER: begin
                // Acceptance wins over a simultaneous valid drop.
                if (out_ready) begin
                    state_d         = RELEASE;
                    src_completed_d = onehot(out_source_q);
                end else if (!src_valid[out_source_q]) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                mask_d  = onehot(out_source_q);
                if (out_source_q == SRC_IDX_W'(NUM_SOURCES - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = out_source_q + SRC_IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, packet latch and registered outputs with synchronous reset.
    always_ff @(posedge nocclk) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            mask_q          <= '0;
            out_packet_q    <= '0;
            out_source_q    <= '0;
            out_valid_q     <= 1'b0;
            src_completed_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            mask_q          <= mask_d;
            out_packet_q    <= out_packet_d;
            out_source_q    <= out_source_d;
            out_valid_q     <= out_valid_d;
            src_completed_q <= src_completed_d;
            busy_q          <= busy_d;
        end
    end

    assign src_completed = src_completed_q;
    assign out_packet    = out_packet_q;
    assign out_source    = out_source_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_packet_transfer_arbiter.sv
// Self-checking bench for packet_transfer_arbiter: vector table of
// single transactions plus hand-written multi-cycle sequences, with a
// scoreboard checking every accepted packet.
module tb_packet_transfer_arbiter;
    import packet_types::*;

    localparam int N = 4;

    logic                   nocclk = 1'b0;
    logic                   rst;
    packet_element_t [N-1:0] src_packet;
    logic [N-1:0]           src_valid;
    logic [N-1:0]           src_completed;
    packet_element_t        out_packet;
    logic [1:0]             out_source;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]      src;
        packet_element_t pkt;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    typedef struct {
        logic [N-1:0] valid;
        logic [1:0]   exp_src;
    } vec_t;
    vec_t vecs[8];

    packet_transfer_arbiter #(.NUM_SOURCES(N)) dut (
        .nocclk        (nocclk),
        .rst           (rst),
        .src_packet    (src_packet),
        .src_valid     (src_valid),
        .src_completed (src_completed),
        .out_packet    (out_packet),
        .out_source    (out_source),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always #5 nocclk = ~nocclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic packet_element_t mkpkt(input int i);
        packet_element_t p;
        p.packet_id = 8'h10 + 8'(i);
        p.dest      = 8'(i * 3);
        p.length    = 8'd4;
        p.addr      = 16'h1000 + 16'(i);
        return p;
    endfunction

    task automatic step();
        @(posedge nocclk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic sb_push(input logic [1:0] s, input packet_element_t p);
        sb_t e;
        e.src = s;
        e.pkt = p;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every handshake must match the oldest expected grant;
    // any completed pulse must be one-hot.
    always @(posedge nocclk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: accepted source %0d with no expected grant", out_source);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_source", 64'(out_source), 64'(sb_e.src));
                check("sb_packet", 64'(out_packet), 64'(sb_e.pkt));
            end
        end
        if (!rst && src_completed != '0) begin
            check("completed_onehot", 64'($countones(src_completed)), 64'(1));
        end
    end

    logic [1:0] grants[$];
    logic [1:0] rr_exp[5];
    int         age[N];
    logic       prev_v;

    initial begin
        vecs[0] = '{4'b1010, 2'd1};
        vecs[1] = '{4'b0011, 2'd0};
        vecs[2] = '{4'b1001, 2'd3};
        vecs[3] = '{4'b1111, 2'd0};
        vecs[4] = '{4'b0001, 2'd0};
        vecs[5] = '{4'b0100, 2'd2};
        vecs[6] = '{4'b0110, 2'd1};
        vecs[7] = '{4'b1000, 2'd3};
        rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < N; i++) src_packet[i] = mkpkt(i);

        // Reset and idle
        rst = 1'b1; src_valid = '0; out_ready = 1'b0;
        step();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_source", 64'(out_source), 64'(0));
        check("rst_packet", 64'(out_packet), 64'(0));
        check("rst_completed", 64'(src_completed), 64'(0));
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_valid", 64'(out_valid), 64'(0));
            check("idle_completed", 64'(src_completed), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
        end

        // Single source, packet_id 5, valid kept through the masked IDLE cycle
        do_reset();
        src_packet[2] = mkpkt(2);
        src_packet[2].packet_id = 8'd5;
        src_valid = 4'b0100; out_ready = 1'b1;
        sb_push(2'd2, src_packet[2]);
        step();
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_source", 64'(out_source), 64'(2));
        check("single_pid", 64'(out_packet.packet_id), 64'(5));
        check("single_busy", 64'(busy), 64'(1));
        step();
        check("single_completed", 64'(src_completed), 64'(4'b0100));
        check("single_valid_release", 64'(out_valid), 64'(0));
        step();
        check("single_completed_once", 64'(src_completed), 64'(0));
        step();
        check("single_no_regrant", 64'(out_valid), 64'(0));
        check("single_idle_busy", 64'(busy), 64'(0));
        src_valid = '0;
        src_packet[2] = mkpkt(2);
        step();

        // Vector table: round-robin choice from the carried-over pointer
        do_reset();
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            src_valid = vecs[v].valid;
            sb_push(vecs[v].exp_src, mkpkt(int'(vecs[v].exp_src)));
            step();
            check("vec_valid", 64'(out_valid), 64'(1));
            check("vec_source", 64'(out_source), 64'(vecs[v].exp_src));
            check("vec_packet", 64'(out_packet), 64'(mkpkt(int'(vecs[v].exp_src))));
            step();
            check("vec_completed", 64'(src_completed), 64'(4'b0001 << vecs[v].exp_src));
            step();
            src_valid = 4'b0001 << vecs[v].exp_src;
            step();
            check("vec_masked", 64'(out_valid), 64'(0));
            src_valid = '0;
            step();
        end

        // Round-robin fairness with sources dropping and re-asserting valid
        do_reset();
        out_ready = 1'b1;
        src_valid = 4'b1111;
        for (int i = 0; i < 5; i++) sb_push(rr_exp[i], mkpkt(int'(rr_exp[i])));
        for (int i = 0; i < N; i++) age[i] = -1;
        prev_v = 1'b0;
        for (int cyc = 0; cyc < 60 && grants.size() < 5; cyc++) begin
            step();
            if (out_valid && !prev_v) grants.push_back(out_source);
            prev_v = out_valid;
            for (int i = 0; i < N; i++) begin
                if (src_completed[i]) age[i] = 0;
                else if (age[i] >= 0) age[i]++;
                if (age[i] == 1) src_valid[i] = 1'b0;
                if (age[i] == 3) begin
                    src_valid[i] = 1'b1;
                    age[i] = -1;
                end
            end
        end
        src_valid = '0;
        repeat (3) step();
        check("rr_count", 64'(grants.size()), 64'(5));
        for (int k = 0; k < grants.size() && k < 5; k++) begin
            check("rr_order", 64'(grants[k]), 64'(rr_exp[k]));
        end

        // Backpressure: packet held while the source changes its copy
        do_reset();
        src_valid = 4'b0010; out_ready = 1'b0;
        step();
        check("bp_source", 64'(out_source), 64'(1));
        for (int k = 0; k < 8; k++) begin
            src_packet[1].packet_id = 8'hA0 + 8'(k);
            step();
            check("bp_packet", 64'(out_packet), 64'(mkpkt(1)));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_completed", 64'(src_completed), 64'(0));
        end
        sb_push(2'd1, mkpkt(1));
        out_ready = 1'b1;
        step();
        check("bp_pulse", 64'(src_completed), 64'(4'b0010));
        step();
        check("bp_pulse_once", 64'(src_completed), 64'(0));
        src_valid = '0;
        src_packet[1] = mkpkt(1);
        step();

        // Abort: source withdraws while not ready; pointer must not move
        do_reset();
        src_valid = 4'b0100; out_ready = 1'b0;
        step();
        check("abort_source", 64'(out_source), 64'(2));
        src_valid = '0;
        step();
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_completed", 64'(src_completed), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        src_valid = 4'b1100; out_ready = 1'b1;
        sb_push(2'd2, mkpkt(2));
        step();
        check("abort_regrant", 64'(out_source), 64'(2));
        step();
        check("abort_pulse", 64'(src_completed), 64'(4'b0100));
        src_valid = '0;
        repeat (2) step();

        // Reset while offering
        do_reset();
        src_valid = 4'b1000; out_ready = 1'b0;
        step();
        check("rstoff_source", 64'(out_source), 64'(3));
        rst = 1'b1;
        step();
        check("rstoff_valid", 64'(out_valid), 64'(0));
        check("rstoff_completed", 64'(src_completed), 64'(0));
        check("rstoff_busy", 64'(busy), 64'(0));
        check("rstoff_src", 64'(out_source), 64'(0));
        check("rstoff_packet", 64'(out_packet), 64'(0));
        rst = 1'b0;
        src_valid = '0;
        step();

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
